// File: rtl/hyst_sched_pkg.sv
// Shared types and constants for the double-buffered hysteresis/hough frame scheduler.
package hyst_sched_pkg;

  localparam int SEQ_W  = 8;
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_WRITING = 2'd1,
    ST_READY   = 2'd2,
    ST_READING = 2'd3
  } bank_state_t;

  // True when tag a was issued before tag b, treating the sequence as a modulo-2^SEQ_W ring.
  function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_W-1];
  endfunction

endpackage

// File: rtl/hyst_bank_mux.sv
// Routes the producer write port and consumer read port onto whichever BRAM bank each side owns.
module hyst_bank_mux #(
  parameter int ADDR_W = 20
) (
  input  logic [1:0]             bank_writing,
  input  logic [1:0]             bank_reading,
  input  logic                   prod_bank,
  input  logic                   cons_bank,
  input  logic                   prod_wr_en,
  input  logic [ADDR_W-1:0]      prod_wr_addr,
  input  logic [7:0]             prod_wr_data,
  input  logic [ADDR_W-1:0]      cons_rd_addr,
  output logic [7:0]             cons_rd_data,
  output logic [1:0]             bank_wr_en,
  output logic [1:0][ADDR_W-1:0] bank_addr,
  output logic [1:0][7:0]        bank_wr_data,
  input  logic [1:0][7:0]        bank_rd_data,
  output logic                   wr_drop
);

  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    bank_wr_en   = '0;
    bank_addr    = '0;
    bank_wr_data = '0;
    for (int b = 0; b < 2; b++) begin
      bank_wr_data[b] = prod_wr_data;
      if (bank_writing[b]) begin
        bank_addr[b]  = prod_wr_addr;
        bank_wr_en[b] = prod_wr_en && (prod_bank == 1'(b));
      end else if (bank_reading[b]) begin
        bank_addr[b] = cons_rd_addr;
      end
    end
  end

  assign cons_rd_data = bank_rd_data[cons_bank];
  assign wr_drop      = prod_wr_en && !bank_writing[prod_bank];

endmodule

// File: rtl/hyst_frame_scheduler.sv
// Ping-pong bank scheduler between a hysteresis frame producer and a hough-pass consumer.
module hyst_frame_scheduler
  import hyst_sched_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   prod_start,
  input  logic                   prod_done,
  input  logic                   prod_wr_en,
  input  logic [ADDR_W-1:0]      prod_wr_addr,
  input  logic [7:0]             prod_wr_data,
  output logic                   cons_start,
  input  logic                   cons_done,
  input  logic [ADDR_W-1:0]      cons_rd_addr,
  output logic [7:0]             cons_rd_data,
  output logic [1:0]             bank_wr_en,
  output logic [1:0][ADDR_W-1:0] bank_addr,
  output logic [1:0][7:0]        bank_wr_data,
  input  logic [1:0][7:0]        bank_rd_data,
  output logic                   prod_bank,
  output logic                   cons_bank,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   err
);

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic [SEQ_W-1:0]  tag_q   [2];
  logic [SEQ_W-1:0]  tag_d   [2];
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              err_q, err_d;
  logic              arm_q, arm_d;
  logic              prod_start_q, prod_start_d;
  logic              cons_start_q, cons_start_d;
  logic              prod_bank_q, prod_bank_d;
  logic              cons_bank_q, cons_bank_d;

  logic [1:0] is_free, is_writing, is_ready, is_reading;
  logic       any_writing, any_reading, wr_idx, rd_idx;
  logic       cons_go, cons_pick;
  logic       wr_drop;

  assign is_free     = {state_q[1] == ST_FREE,    state_q[0] == ST_FREE};
  assign is_writing  = {state_q[1] == ST_WRITING, state_q[0] == ST_WRITING};
  assign is_ready    = {state_q[1] == ST_READY,   state_q[0] == ST_READY};
  assign is_reading  = {state_q[1] == ST_READING, state_q[0] == ST_READING};
  assign any_writing = |is_writing;
  assign any_reading = |is_reading;
  assign wr_idx      = is_writing[1];
  assign rd_idx      = is_reading[1];

  // Consumer choice is resolved first so the producer never steals the bank being handed over.
  assign cons_go   = !any_reading && (|is_ready);
  assign cons_pick = (&is_ready) ? seq_older(tag_q[1], tag_q[0]) : is_ready[1];

  // NOTE: sequential state uses non-blocking assignments only; next-state logic stays in always_comb.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= '{ST_FREE, ST_FREE};
      tag_q        <= '{default: '0};
      seq_q        <= '0;
      drop_q       <= '0;
      err_q        <= 1'b0;
      arm_q        <= 1'b0;
      prod_start_q <= 1'b0;
      cons_start_q <= 1'b0;
      prod_bank_q  <= 1'b0;
      cons_bank_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      seq_q        <= seq_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
      arm_q        <= arm_d;
      prod_start_q <= prod_start_d;
      cons_start_q <= cons_start_d;
      prod_bank_q  <= prod_bank_d;
      cons_bank_q  <= cons_bank_d;
    end
  end

  // Start decisions look only at registered state, so a bank freed this cycle is reusable next cycle.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    seq_d        = seq_q;
    drop_d       = drop_q;
    err_d        = err_q || wr_drop;
    arm_d        = 1'b1;
    prod_start_d = 1'b0;
    cons_start_d = 1'b0;
    prod_bank_d  = prod_bank_q;
    cons_bank_d  = cons_bank_q;

    if (prod_done) begin
      if (any_writing) begin
        state_d[wr_idx] = ST_READY;
        tag_d[wr_idx]   = seq_q;
        seq_d           = seq_q + SEQ_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    if (cons_done) begin
      if (any_reading) state_d[rd_idx] = ST_FREE;
      else             err_d = 1'b1;
    end

    if (cons_go) begin
      state_d[cons_pick] = ST_READING;
      cons_start_d       = 1'b1;
      cons_bank_d        = cons_pick;
    end

    if (arm_q && enable && !any_writing) begin
      if (|is_free) begin
        state_d[!is_free[0]] = ST_WRITING;
        prod_start_d         = 1'b1;
        prod_bank_d          = !is_free[0];
      end else if (is_ready[0] && !(cons_go && !cons_pick)) begin
        state_d[0]   = ST_WRITING;
        prod_start_d = 1'b1;
        prod_bank_d  = 1'b0;
        drop_d       = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
      end else if (is_ready[1] && !(cons_go && cons_pick)) begin
        state_d[1]   = ST_WRITING;
        prod_start_d = 1'b1;
        prod_bank_d  = 1'b1;
        drop_d       = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
      end
    end
  end

  always_comb begin
    prod_start = prod_start_q;
    cons_start = cons_start_q;
    prod_bank  = prod_bank_q;
    cons_bank  = cons_bank_q;
    drop_count = drop_q;
    err        = err_q;
  end

  hyst_bank_mux #(
    .ADDR_W(ADDR_W)
  ) u_bank_mux (
    .bank_writing (is_writing),
    .bank_reading (is_reading),
    .prod_bank    (prod_bank_q),
    .cons_bank    (cons_bank_q),
    .prod_wr_en   (prod_wr_en),
    .prod_wr_addr (prod_wr_addr),
    .prod_wr_data (prod_wr_data),
    .cons_rd_addr (cons_rd_addr),
    .cons_rd_data (cons_rd_data),
    .bank_wr_en   (bank_wr_en),
    .bank_addr    (bank_addr),
    .bank_wr_data (bank_wr_data),
    .bank_rd_data (bank_rd_data),
    .wr_drop      (wr_drop)
  );

endmodule

// File: tb/tb_hyst_frame_scheduler.sv
// Directed bench for hyst_frame_scheduler with two behavioural 1-cycle-latency BRAM banks.
module tb_hyst_frame_scheduler;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int ADDR_W = 5;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   enable;
  logic                   prod_start;
  logic                   prod_done;
  logic                   prod_wr_en;
  logic [ADDR_W-1:0]      prod_wr_addr;
  logic [7:0]             prod_wr_data;
  logic                   cons_start;
  logic                   cons_done;
  logic [ADDR_W-1:0]      cons_rd_addr;
  logic [7:0]             cons_rd_data;
  logic [1:0]             bank_wr_en;
  logic [1:0][ADDR_W-1:0] bank_addr;
  logic [1:0][7:0]        bank_wr_data;
  logic [1:0][7:0]        bank_rd_data;
  logic                   prod_bank;
  logic                   cons_bank;
  logic [15:0]            drop_count;
  logic                   err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bank_wr_en[0]) mem0[bank_addr[0]] <= bank_wr_data[0];
    if (bank_wr_en[1]) mem1[bank_addr[1]] <= bank_wr_data[1];
    bank_rd_data[0] <= mem0[bank_addr[0]];
    bank_rd_data[1] <= mem1[bank_addr[1]];
  end

  hyst_frame_scheduler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .prod_start(prod_start), .prod_done(prod_done),
    .prod_wr_en(prod_wr_en), .prod_wr_addr(prod_wr_addr), .prod_wr_data(prod_wr_data),
    .cons_start(cons_start), .cons_done(cons_done),
    .cons_rd_addr(cons_rd_addr), .cons_rd_data(cons_rd_data),
    .bank_wr_en(bank_wr_en), .bank_addr(bank_addr), .bank_wr_data(bank_wr_data),
    .bank_rd_data(bank_rd_data),
    .prod_bank(prod_bank), .cons_bank(cons_bank),
    .drop_count(drop_count), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; prod_done = 1'b0; cons_done = 1'b0;
    prod_wr_en = 1'b0; prod_wr_addr = '0; prod_wr_data = '0; cons_rd_addr = '0;
    step(); step();
    check("rst_prod_start", prod_start, 0);
    check("rst_cons_start", cons_start, 0);
    check("rst_prod_bank", prod_bank, 0);
    check("rst_cons_bank", cons_bank, 0);
    check("rst_drop", drop_count, 0);
    check("rst_err", err, 0);
    check("rst_wr_en", bank_wr_en, 0);

    // First frame: start delayed two cycles after reset release
    reset = 1'b0; enable = 1'b1;
    step();
    check("arm_no_start", prod_start, 0);
    step();
    check("f1_prod_start", prod_start, 1);
    check("f1_prod_bank", prod_bank, 0);
    step();
    check("f1_start_pulse", prod_start, 0);

    prod_wr_en = 1'b1; prod_wr_addr = 5'd5; prod_wr_data = 8'hAB;
    #1;
    check("f1_wr_en", bank_wr_en, 2'b01);
    check("f1_wr_addr", bank_addr[0], 5);
    check("f1_wr_data", bank_wr_data[0], 8'hAB);
    step();
    prod_wr_en = 1'b0;
    prod_done = 1'b1;
    step();
    prod_done = 1'b0;
    check("f1_done_no_cons_yet", cons_start, 0);
    step();
    check("f1_cons_start", cons_start, 1);
    check("f1_cons_bank", cons_bank, 0);
    check("f2_prod_start", prod_start, 1);
    check("f2_prod_bank", prod_bank, 1);

    cons_rd_addr = 5'd5; prod_wr_addr = 5'd9;
    #1;
    check("rd_addr_bank0", bank_addr[0], 5);
    check("wr_addr_bank1", bank_addr[1], 9);
    step();
    check("rd_data", cons_rd_data, 8'hAB);

    // Second frame completes while consumer still holds bank 0: third start steals bank 1
    prod_done = 1'b1;
    step();
    prod_done = 1'b0;
    check("f2_done_no_start", prod_start, 0);
    step();
    check("f3_prod_start", prod_start, 1);
    check("f3_prod_bank", prod_bank, 1);
    check("f3_drop", drop_count, 1);
    check("f3_cons_bank", cons_bank, 0);
    check("f3_no_cons_start", cons_start, 0);

    // Same-cycle prod_done and cons_done
    prod_done = 1'b1; cons_done = 1'b1;
    step();
    prod_done = 1'b0; cons_done = 1'b0;
    check("both_no_prod_start", prod_start, 0);
    check("both_no_cons_start", cons_start, 0);
    check("both_err", err, 0);
    step();
    check("both_prod_start", prod_start, 1);
    check("both_prod_bank", prod_bank, 0);
    check("both_cons_start", cons_start, 1);
    check("both_cons_bank", cons_bank, 1);

    // Disable new frames, then a spurious cons_done
    enable = 1'b0;
    cons_done = 1'b1;
    step();
    check("valid_cons_done_err", err, 0);
    step();
    cons_done = 1'b0;
    check("spurious_cons_done_err", err, 1);
    check("spurious_cons_bank", cons_bank, 1);
    check("spurious_no_cons_start", cons_start, 0);

    prod_done = 1'b1;
    step();
    prod_done = 1'b0;
    step();
    check("dis_cons_start", cons_start, 1);
    check("dis_cons_bank", cons_bank, 0);
    check("dis_no_prod_start", prod_start, 0);
    step();
    check("dis_still_no_prod", prod_start, 0);

    prod_wr_en = 1'b1;
    #1;
    check("stray_wr_blocked", bank_wr_en, 0);
    step();
    prod_wr_en = 1'b0;
    check("err_sticky", err, 1);

    enable = 1'b1;
    step();
    check("f5_prod_start", prod_start, 1);
    check("f5_prod_bank", prod_bank, 1);
    check("f5_drop_kept", drop_count, 1);
    prod_wr_en = 1'b1; prod_wr_addr = 5'd3; cons_rd_addr = 5'd7;
    #1;
    check("f5_wr_en", bank_wr_en, 2'b10);
    check("f5_addr1", bank_addr[1], 3);
    check("f5_addr0", bank_addr[0], 7);

    // Asynchronous reset in the middle of a frame
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_prod_bank", prod_bank, 0);
    check("mid_rst_cons_bank", cons_bank, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_wr_en", bank_wr_en, 0);
    check("mid_rst_addr0", bank_addr[0], 0);
    prod_wr_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("restart_arm", prod_start, 0);
    step();
    check("restart_prod_start", prod_start, 1);
    check("restart_prod_bank", prod_bank, 0);
    check("restart_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
